// File: rtl/score_recorder_pkg.sv
// score_pkg: types and constants shared by the score recorder, the score
// storage memory and the HEX display logic.
//   rec_state_t : recorder states (CLEAR is only reached when the build
//                 defines SCORE_RECORDER_CLEAR_EN)
//   SCORE_W     : score / storage data width
//   ADDR_W      : storage address width (log depth = 2**ADDR_W)
//   MAX_SCORE   : saturation value of a single game score
//   score_t     : one stored score
package score_pkg;

    localparam int unsigned SCORE_W   = 10;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned MAX_SCORE = (1 << SCORE_W) - 1;

    typedef enum logic [1:0] {
        IDLE,
        PLAYING,
        WRITE,
        CLEAR
    } rec_state_t;

    typedef logic [SCORE_W-1:0] score_t;

endpackage

// File: rtl/score_recorder_if.sv
// score_recorder_if: upstream game pulses plus the storage write port.
//   game_start, point, game_over : single-cycle pulses from the game logic
//   busy                         : recorder is writing/clearing, pulses ignored
//   address, data, wren          : storage memory write port
// Modports:
//   master : the recorder (consumes pulses, drives the write port)
//   slave  : the game logic / storage side
interface score_recorder_if #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned SCORE_W = 10
);
    logic               game_start;
    logic               point;
    logic               game_over;
    logic               busy;
    logic [ADDR_W-1:0]  address;
    logic [SCORE_W-1:0] data;
    logic               wren;

    modport master (
        input  game_start, point, game_over,
        output busy, address, data, wren
    );

    modport slave (
        output game_start, point, game_over,
        input  busy, address, data, wren
    );
endinterface

// File: rtl/score_recorder_sat_counter.sv
// sat_counter: up-counter with enable, synchronous clear and saturation.
//   clock, reset_n : system clock, asynchronous active-low reset
//   clear          : synchronous clear to zero (has priority over enable)
//   enable         : increment by one unless already at MAX
//   count          : current value
module sat_counter #(
    parameter int unsigned        WIDTH = 8,
    parameter logic [WIDTH-1:0]   MAX   = '1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/score_recorder.sv
// score_recorder: tracks the running score of a game and commits the final
// score as a single-cycle write into the next slot of a circular log held in
// the score storage memory.
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus            : score_recorder_if.master (game pulses in, busy and
//                    registered storage write port out)
//   current_score  : live score of the current / last game
//   games_played   : committed games, saturating at 2**ADDR_W
// Build option SCORE_RECORDER_CLEAR_EN: after reset the whole log is written
// with zeros (one entry per cycle) before the first game is accepted.
module score_recorder #(
    parameter int unsigned ADDR_W  = score_pkg::ADDR_W,
    parameter int unsigned SCORE_W = score_pkg::SCORE_W
) (
    input  logic               clock,
    input  logic               reset_n,
    score_recorder_if.master   bus,
    output logic [SCORE_W-1:0] current_score,
    output logic [ADDR_W:0]    games_played
);
    import score_pkg::*;

    localparam logic [ADDR_W:0]    GAMES_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    rec_state_t         state;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [SCORE_W-1:0] score_final;
    logic               score_clear;
    logic               score_en;
    logic               games_en;

    assign score_clear = (state == IDLE)    && bus.game_start;
    assign score_en    = (state == PLAYING) && bus.point;
    assign games_en    = (state == WRITE);

    // The commit is registered on the game_over edge, so it must already
    // include a point arriving in that same cycle.
    always_comb begin
        score_final = current_score;
        if (bus.point && (current_score != SCORE_MAX)) begin
            score_final = current_score + 1'b1;
        end
    end

    sat_counter #(
        .WIDTH (SCORE_W),
        .MAX   (SCORE_MAX)
    ) u_score (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (score_clear),
        .enable  (score_en),
        .count   (current_score)
    );

    sat_counter #(
        .WIDTH (ADDR_W + 1),
        .MAX   (GAMES_MAX)
    ) u_games (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (1'b0),
        .enable  (games_en),
        .count   (games_played)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
`ifdef SCORE_RECORDER_CLEAR_EN
            state   <= CLEAR;
`else
            state   <= IDLE;
`endif
            wr_ptr      <= '0;
            bus.address <= '0;
            bus.data    <= '0;
            bus.wren    <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.game_start) begin
                        state <= PLAYING;
                    end
                end
                PLAYING: begin
                    if (bus.game_over) begin
                        state       <= WRITE;
                        bus.wren    <= 1'b1;
                        bus.busy    <= 1'b1;
                        bus.address <= wr_ptr;
                        bus.data    <= score_final;
                    end
                end
                WRITE: begin
                    state    <= IDLE;
                    bus.wren <= 1'b0;
                    bus.busy <= 1'b0;
                    wr_ptr   <= wr_ptr + 1'b1;
                end
`ifdef SCORE_RECORDER_CLEAR_EN
                CLEAR: begin
                    // Leave only once the last entry's write cycle has
                    // been presented, so busy covers every clear write.
                    if (bus.wren && (bus.address == '1)) begin
                        state    <= IDLE;
                        bus.wren <= 1'b0;
                        bus.busy <= 1'b0;
                        wr_ptr   <= '0;
                    end else begin
                        bus.wren    <= 1'b1;
                        bus.busy    <= 1'b1;
                        bus.address <= wr_ptr;
                        bus.data    <= '0;
                        wr_ptr      <= wr_ptr + 1'b1;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    bus.wren <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/score_recorder.md
Name: score_recorder

Overview:
- Upstream feeder for the score storage memory (32 x 10-bit, write port address/data/wren, top-3 readout).
- Tracks the running score of the current game, then commits the final score on game over as a single-cycle write to the next slot of a circular 32-entry log.
- Also exports live score and game count for HEX display logic.

Parameters:
ADDR_W, 5, storage address width; log depth = 2**ADDR_W entries.
SCORE_W, 10, score/data width; must match storage data width.

Ports:
clock  input  1  system clock, all state on posedge.
reset_n  input  1  asynchronous active-low reset.
game_start  input  1  single-cycle pulse; begins a new game.
point  input  1  single-cycle pulse; +1 to current score.
game_over  input  1  single-cycle pulse; ends game, triggers commit.
address  output  ADDR_W  storage write address (registered).
data  output  SCORE_W  storage write data (registered).
wren  output  1  storage write enable (registered, one cycle per commit).
current_score  output  SCORE_W  live score of current/last game.
games_played  output  ADDR_W+1  committed games, saturating at 2**ADDR_W.
busy  output  1  high while in WRITE or CLEAR; upstream inputs ignored.

Behaviour:
- Reset (async assert, sync release): state IDLE (or CLEAR, see option). address=0, data=0, wren=0, current_score=0, games_played=0, busy=0, wr_ptr=0.
- States: IDLE, PLAYING, WRITE (plus CLEAR with option).
- IDLE: game_start -> PLAYING and current_score cleared to 0 on the same edge. point and game_over ignored. The last score stays visible until the next start.
- PLAYING: each point increments current_score. Saturates at 2**SCORE_W-1 (1023); never wraps. game_start ignored (no restart mid-game). game_over -> WRITE.
- point and game_over in the same cycle: the point is counted first, so the committed score includes it.
- WRITE: lasts exactly one cycle.
  - wren=1, address=wr_ptr, data=current_score.
  - On exit: wr_ptr <= wr_ptr+1 mod 2**ADDR_W (31 -> 0, overwriting the oldest entry); games_played++ (saturating at 32); -> IDLE.
  - All inputs ignored in this cycle; busy=1.
- Latency: game_over sampled at edge N -> wren high during cycle N+1 -> low from edge N+2.
- wren is never high outside WRITE/CLEAR. address and data hold their last values when wren=0.
- Reset asserted mid-game or mid-WRITE: wren drops immediately. The partial score is discarded and wr_ptr returns to 0.

Optional Feature:
- Macro: SCORE_RECORDER_CLEAR_EN.
- Defined:
  - Reset release enters CLEAR instead of IDLE.
  - CLEAR drives wren=1, data=0, with address stepping 0..31, one entry per cycle, for 32 cycles. The storage memory has no reset, so this zeroes it.
  - Then -> IDLE with wr_ptr=0.
  - busy=1 throughout; game_start during CLEAR is ignored.
- Not defined: the CLEAR state and logic are absent, reset goes straight to IDLE, and storage contents are undefined until written.

Decomposition:
- Package score_pkg:
  - typedef enum rec_state_t {IDLE, PLAYING, WRITE, CLEAR}.
  - Constants SCORE_W=10, ADDR_W=5, MAX_SCORE=1023.
  - typedef score_t = logic [SCORE_W-1:0].
  - Shared with the storage and display blocks.
- One natural sub-module, sat_counter: parameterised width, enable, synchronous clear, saturating increment. Instantiated for current_score and for games_played.

Test Plan:
- Reset, start, 7 point pulses, game_over -> one wren pulse exactly one cycle after game_over, with address=0, data=7; games_played=1; busy high for that cycle only.
- 33 games, game k (k=0..32) scoring k points -> game 33 writes address=0, data=32 (wrap); games_played saturates at 32.
- point pulse every cycle for 1100 cycles, then game_over -> data=1023, no wrap to small value.
- point and game_over in same cycle after score 4 -> data=5. game_start during PLAYING and during WRITE -> no effect on score or state.
- reset_n low mid-PLAYING at score 9 -> wren=0 immediately, current_score=0. Next game of 2 points writes address=0, data=2.
- With SCORE_RECORDER_CLEAR_EN: reset release -> 32 consecutive wren cycles, address 0..31, data=0, busy=1. game_start at cycle 10 is ignored. IDLE afterwards, and the first game writes address 0.
